// File: rtl/lot_pkg.sv
// Shared types and sensor-vector encodings for the parking-lot gate arbiter.
package lot_pkg;

  typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, CLOSE} gate_state_t;
  typedef enum logic {DIR_IN, DIR_OUT} dir_t;

  // Sensor vectors are {outer_blk, inner_blk}.
  localparam logic [1:0] S_CLR  = 2'b00;
  localparam logic [1:0] S_OUT  = 2'b10;
  localparam logic [1:0] S_BOTH = 2'b11;
  localparam logic [1:0] S_IN   = 2'b01;

  // Vector expected at position idx of a passage; position 0 doubles as the final clear step.
  function automatic logic [1:0] seq_vec(input dir_t dir, input logic [1:0] idx);
    logic [1:0] v;
    case (idx)
      2'd0:    v = S_CLR;
      2'd1:    v = (dir == DIR_IN) ? S_OUT : S_IN;
      2'd2:    v = S_BOTH;
      default: v = (dir == DIR_IN) ? S_IN : S_OUT;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/car_pass_detector.sv
// Tracks one car through the outer/inner sensor pair in the requested direction.
module car_pass_detector
  import lot_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  dir_t       dir,
  input  logic       outer_blk,
  input  logic       inner_blk,
  output logic       advance,
  output logic       done,
  output logic [1:0] dbg_step
);

  logic [1:0] step;
  logic [1:0] step_nxt;
  logic [1:0] vec;

  // A held vector keeps the step; anything but the next vector restarts the passage.
  always_comb begin
    vec      = {outer_blk, inner_blk};
    advance  = 1'b0;
    done     = 1'b0;
    step_nxt = 2'd0;
    if (enable) begin
      if (vec == seq_vec(dir, step + 2'd1)) begin
        advance  = 1'b1;
        done     = (step == 2'd3);
        step_nxt = step + 2'd1;
      end else if (vec == seq_vec(dir, step)) begin
        step_nxt = step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step <= 2'd0;
    else          step <= step_nxt;
  end

  assign dbg_step = step;

endmodule

// File: rtl/lot_gate_arbiter.sv
// Shares one lot gate between entry and exit lanes, counts passing cars and tracks occupancy.
module lot_gate_arbiter
  import lot_pkg::*;
#(
  parameter int CAPACITY = 25,
  parameter int COUNT_W  = 5,
  parameter int TIMEOUT  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic               outer_blk,
  input  logic               inner_blk,
  output logic               gate_open,
  output logic               entry_grant,
  output logic               exit_grant,
  output logic               car_entered,
  output logic               car_exited,
  output logic               grant_abort,
  output logic [COUNT_W-1:0] occupancy,
  output logic               lot_full,
  output logic               lot_empty,
  output gate_state_t        dbg_state
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  gate_state_t        state, state_nxt;
  dir_t               last_served, last_nxt;
  logic [TW-1:0]      idle_cnt, idle_nxt;
  logic [COUNT_W-1:0] occ_nxt;
  logic               entered_nxt, exited_nxt, abort_nxt;
  logic               el_in, el_out;
  logic               det_en, det_adv, det_done;
  logic [1:0]         det_step;
  dir_t               det_dir;

  assign det_en  = (state == GRANT_IN) || (state == GRANT_OUT);
  assign det_dir = (state == GRANT_OUT) ? DIR_OUT : DIR_IN;
  assign el_in   = entry_req & ~lot_full;
  assign el_out  = exit_req & ~lot_empty;

  car_pass_detector u_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (det_en),
    .dir      (det_dir),
    .outer_blk(outer_blk),
    .inner_blk(inner_blk),
    .advance  (det_adv),
    .done     (det_done),
    .dbg_step (det_step)
  );

  always_comb begin
    state_nxt   = state;
    last_nxt    = last_served;
    idle_nxt    = idle_cnt;
    occ_nxt     = occupancy;
    entered_nxt = 1'b0;
    exited_nxt  = 1'b0;
    abort_nxt   = 1'b0;
    case (state)
      IDLE: begin
        idle_nxt = '0;
        // Under contention the lane that was not served last wins.
        if (el_in && (!el_out || last_served == DIR_OUT)) begin
          state_nxt = GRANT_IN;
          last_nxt  = DIR_IN;
        end else if (el_out) begin
          state_nxt = GRANT_OUT;
          last_nxt  = DIR_OUT;
        end
      end
      GRANT_IN, GRANT_OUT: begin
        if (det_done) begin
          state_nxt = CLOSE;
          if (state == GRANT_IN) begin
            entered_nxt = 1'b1;
            if (occupancy != CAP) occ_nxt = occupancy + COUNT_W'(1);
          end else begin
            exited_nxt = 1'b1;
            if (occupancy != '0) occ_nxt = occupancy - COUNT_W'(1);
          end
        end else if (det_adv) begin
          idle_nxt = '0;
        end else if (det_step == 2'd0) begin
          if (idle_cnt == IDLE_LAST) begin
            abort_nxt = 1'b1;
            state_nxt = CLOSE;
          end else begin
            idle_nxt = idle_cnt + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= DIR_OUT;
      idle_cnt    <= '0;
      occupancy   <= '0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      gate_open   <= 1'b0;
      car_entered <= 1'b0;
      car_exited  <= 1'b0;
      grant_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      idle_cnt    <= idle_nxt;
      occupancy   <= occ_nxt;
      entry_grant <= (state_nxt == GRANT_IN);
      exit_grant  <= (state_nxt == GRANT_OUT);
      gate_open   <= (state_nxt == GRANT_IN) || (state_nxt == GRANT_OUT);
      car_entered <= entered_nxt;
      car_exited  <= exited_nxt;
      grant_abort <= abort_nxt;
    end
  end

  assign lot_full  = (occupancy == CAP);
  assign lot_empty = (occupancy == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_lot_gate_arbiter.sv
// Bench for lot_gate_arbiter: vector table, directed corner sequences, random run against a model.
module tb_lot_gate_arbiter;
  import lot_pkg::*;

  localparam int CAPACITY = 25;
  localparam int COUNT_W  = 5;
  localparam int TIMEOUT  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic entry_req = 1'b0, exit_req = 1'b0, outer_blk = 1'b0, inner_blk = 1'b0;
  logic gate_open, entry_grant, exit_grant, car_entered, car_exited, grant_abort;
  logic lot_full, lot_empty;
  logic [COUNT_W-1:0] occupancy;
  gate_state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lot_gate_arbiter #(.CAPACITY(CAPACITY), .COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .outer_blk(outer_blk), .inner_blk(inner_blk), .gate_open(gate_open),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .car_entered(car_entered),
    .car_exited(car_exited), .grant_abort(grant_abort), .occupancy(occupancy),
    .lot_full(lot_full), .lot_empty(lot_empty), .dbg_state(dbg_state)
  );

  // Reference model: owner 0 = nobody, 1 = entry lane, 2 = exit lane.
  logic [1:0] seq_in  [0:4] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] seq_out [0:4] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  int m_occ, m_owner, m_prog, m_idle;
  bit m_last_in, m_closing, m_ent, m_ext, m_abort;

  task automatic model_reset();
    m_occ = 0; m_owner = 0; m_prog = 0; m_idle = 0;
    m_last_in = 0; m_closing = 0; m_ent = 0; m_ext = 0; m_abort = 0;
  endtask

  task automatic model_step(input bit rin, input bit rout, input bit o, input bit i);
    logic [1:0] v, nv, cv;
    bit el_in, el_out;
    v = {o, i};
    m_ent = 0; m_ext = 0; m_abort = 0;
    if (m_closing) begin
      m_closing = 0;
    end else if (m_owner == 0) begin
      el_in  = rin && (m_occ < CAPACITY);
      el_out = rout && (m_occ > 0);
      if (el_in && (!el_out || !m_last_in)) begin m_owner = 1; m_last_in = 1; end
      else if (el_out) begin m_owner = 2; m_last_in = 0; end
      m_prog = 0; m_idle = 0;
    end else begin
      nv = (m_owner == 1) ? seq_in[m_prog + 1] : seq_out[m_prog + 1];
      cv = (m_owner == 1) ? seq_in[m_prog] : seq_out[m_prog];
      if (v == nv) begin
        m_prog++; m_idle = 0;
      end else begin
        if (m_prog == 0) m_idle++;
        if (v != cv) m_prog = 0;
      end
      if (m_prog == 4) begin
        if (m_owner == 1) begin m_ent = 1; if (m_occ < CAPACITY) m_occ++; end
        else begin m_ext = 1; if (m_occ > 0) m_occ--; end
        m_owner = 0; m_closing = 1; m_prog = 0;
      end else if (m_idle == TIMEOUT) begin
        m_abort = 1; m_owner = 0; m_closing = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("gate_open",   gate_open,   m_owner != 0);
    chk("entry_grant", entry_grant, m_owner == 1);
    chk("exit_grant",  exit_grant,  m_owner == 2);
    chk("car_entered", car_entered, m_ent);
    chk("car_exited",  car_exited,  m_ext);
    chk("grant_abort", grant_abort, m_abort);
    chk("occupancy",   occupancy,   m_occ);
    chk("lot_full",    lot_full,    m_occ == CAPACITY);
    chk("lot_empty",   lot_empty,   m_occ == 0);
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, compare 1 ns later.
  task automatic cyc(input bit rin, input bit rout, input bit o, input bit i);
    entry_req = rin; exit_req = rout; outer_blk = o; inner_blk = i;
    @(posedge clk);
    model_step(rin, rout, o, i);
    #1;
    check_model();
  endtask

  // Request one lane, wait for its grant, then walk one car through and close.
  task automatic pass_car(input bit is_in);
    int guard = 0;
    cyc(is_in, !is_in, 0, 0);
    while (!(is_in ? entry_grant : exit_grant) && guard < 40) begin
      cyc(is_in, !is_in, 0, 0);
      guard++;
    end
    if (guard >= 40) chk("pass_car_grant_wait", 0, 1);
    for (int k = 1; k <= 4; k++) begin
      if (is_in) cyc(0, 0, seq_in[k][1], seq_in[k][0]);
      else       cyc(0, 0, seq_out[k][1], seq_out[k][0]);
    end
    chk("pass_car_pulse", is_in ? car_entered : car_exited, 1);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit rin, rout, o, i;
    bit eg, xg, gate, ent, ext, abt;
    int occ;
  } vec_t;
  vec_t tbl[$];

  bit want_in, seen_abort, seen_cnt;
  int guard;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("reset_gate", gate_open, 0);
    chk("reset_occ", occupancy, 0);
    chk("reset_empty", lot_empty, 1);
    chk("reset_full", lot_full, 0);
    chk("reset_state", dbg_state, IDLE);

    // rin rout o i | eg xg gate ent ext abt occ
    tbl.push_back(vec_t'{1,0,0,0, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{1,0,0,0, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,1,0, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,1,1, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,0,1, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,0,0, 0,0,0,1,0,0, 1});
    tbl.push_back(vec_t'{0,0,0,0, 0,0,0,0,0,0, 1});
    tbl.push_back(vec_t'{0,1,0,0, 0,1,1,0,0,0, 1});
    tbl.push_back(vec_t'{0,1,0,1, 0,1,1,0,0,0, 1});
    tbl.push_back(vec_t'{0,0,1,1, 0,1,1,0,0,0, 1});
    tbl.push_back(vec_t'{0,0,1,0, 0,1,1,0,0,0, 1});
    tbl.push_back(vec_t'{0,0,0,0, 0,0,0,0,1,0, 0});
    tbl.push_back(vec_t'{0,1,0,0, 0,0,0,0,0,0, 0});
    tbl.push_back(vec_t'{0,1,0,0, 0,0,0,0,0,0, 0});
    tbl.push_back(vec_t'{1,1,0,0, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,1,0, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,1,1, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,0,1, 1,0,1,0,0,0, 0});
    tbl.push_back(vec_t'{0,0,0,0, 0,0,0,1,0,0, 1});
    tbl.push_back(vec_t'{0,0,0,0, 0,0,0,0,0,0, 1});
    foreach (tbl[k]) begin
      entry_req = tbl[k].rin; exit_req = tbl[k].rout;
      outer_blk = tbl[k].o; inner_blk = tbl[k].i;
      @(posedge clk);
      model_step(tbl[k].rin, tbl[k].rout, tbl[k].o, tbl[k].i);
      #1;
      chk("tbl_entry_grant", entry_grant, tbl[k].eg);
      chk("tbl_exit_grant",  exit_grant,  tbl[k].xg);
      chk("tbl_gate_open",   gate_open,   tbl[k].gate);
      chk("tbl_car_entered", car_entered, tbl[k].ent);
      chk("tbl_car_exited",  car_exited,  tbl[k].ext);
      chk("tbl_grant_abort", grant_abort, tbl[k].abt);
      chk("tbl_occupancy",   occupancy,   tbl[k].occ);
    end

    // Exit order counts (5 -> 4); entry order on an exit grant never counts.
    repeat (4) pass_car(1);
    pass_car(0);
    chk("exit_occ_4", occupancy, 4);
    cyc(0, 1, 0, 0);
    chk("wrong_order_grant", exit_grant, 1);
    for (int k = 1; k <= 4; k++) cyc(0, 0, seq_in[k][1], seq_in[k][0]);
    seen_abort = 0; seen_cnt = 0; guard = 0;
    while (!seen_abort && guard < 20) begin
      cyc(0, 0, 0, 0);
      seen_abort |= grant_abort; seen_cnt |= car_exited;
      guard++;
    end
    chk("wrong_order_abort", seen_abort, 1);
    chk("wrong_order_no_count", seen_cnt, 0);
    chk("wrong_order_occ", occupancy, 4);
    cyc(0, 0, 0, 0);

    // Contention from occupancy 3 with exit served last: in, out, in, out.
    pass_car(0);
    want_in = 1;
    for (int g = 0; g < 4; g++) begin
      chk("rr_gate_closed", gate_open, 0);
      guard = 0;
      do begin cyc(1, 1, 0, 0); guard++; end while (!gate_open && guard < 10);
      chk("rr_gap_cycles", guard, (g == 0) ? 1 : 2);
      chk("rr_entry_grant", entry_grant, want_in);
      chk("rr_exit_grant", exit_grant, !want_in);
      guard = 0;
      while (gate_open && guard < 20) begin cyc(1, 1, 0, 0); guard++; end
      chk("rr_closed_state", dbg_state, CLOSE);
      want_in = !want_in;
    end
    cyc(0, 0, 0, 0);

    // Full lot refuses entry; empty lot refuses exit.
    for (int k = 0; k < 30 && m_occ < CAPACITY; k++) pass_car(1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0);
      chk("full_no_grant", entry_grant, 0);
      chk("full_flag", lot_full, 1);
    end
    for (int k = 0; k < 30 && m_occ > 0; k++) pass_car(0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 0);
      chk("empty_no_grant", exit_grant, 0);
      chk("empty_state_idle", dbg_state, IDLE);
    end

    // Backout then timeout: 00,10,00 then 00 until abort.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    seen_abort = 0; seen_cnt = 0; guard = 0;
    while (!seen_abort && guard < 20) begin
      cyc(0, 0, 0, 0);
      seen_abort |= grant_abort; seen_cnt |= car_entered;
      guard++;
    end
    chk("backout_abort", seen_abort, 1);
    chk("backout_timeout_len", guard, TIMEOUT);
    chk("backout_no_entry", seen_cnt, 0);
    chk("backout_occ", occupancy, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset between edges in the middle of a passage.
    pass_car(1);
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_gate", gate_open, 0);
    chk("async_entry_grant", entry_grant, 0);
    chk("async_occ", occupancy, 0);
    chk("async_empty", lot_empty, 1);
    chk("async_state", dbg_state, IDLE);
    model_reset();
    @(negedge clk);
    entry_req = 0; exit_req = 0; outer_blk = 0; inner_blk = 0;
    reset_n = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("after_reset_idle", dbg_state, IDLE);

    // Random traffic, biased toward following the granted lane's passage.
    for (int k = 0; k < 3000; k++) begin
      bit rin, rout;
      logic [1:0] v;
      int r;
      rin  = ($urandom_range(0, 99) < 50);
      rout = ($urandom_range(0, 99) < 45);
      r    = $urandom_range(0, 9);
      if (m_owner != 0 && r < 7) v = (m_owner == 1) ? seq_in[m_prog + 1] : seq_out[m_prog + 1];
      else v = 2'($urandom_range(0, 3));
      cyc(rin, rout, v[1], v[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
